// File: rtl/sevenseg_receiver.sv
// -----------------------------------------------------------------------------
// sevenseg_receiver
//
// Watches a 7-segment display bus and recovers the digit it shows. The bus is
// registered once and then debounced. A pattern commits only after it has been
// seen unchanged for a full stability window, and only if it differs from the
// last committed pattern. The first pattern after reset always commits. Each
// commit updates the decoded outputs, pulses 'update' and pushes the decoded
// result into a small show-ahead FIFO.
//
// Ports
//   clk           : system clock, all state on the rising edge
//   rst_n         : asynchronous active-low reset
//   seg[6:0]      : segment bus, active-high, bit0 = a .. bit6 = g
//   value[3:0]    : last committed digit (0-9, 12 = blank, 15 = unknown)
//   valid         : high once any pattern has committed
//   update        : one-cycle pulse in the cycle after each commit edge
//   bad_pattern   : committed pattern is not in the decode table
//   change_count  : commits since reset, saturating at 255
//   rd_en         : pop the FIFO head (ignored when the FIFO is empty)
//   rd_data[4:0]  : FIFO head {bad, value}, reads 0 when the FIFO is empty
//   fifo_empty    : FIFO holds no entries
//   fifo_full     : FIFO holds 4 entries
//   overflow      : sticky; a commit was dropped because the FIFO was full
//   state_o       : FSM state for debug (0 = WAIT, 1 = LOCKED)
//
// FIFO handshake: a pop happens on a rising edge where rd_en=1 and
// fifo_empty=0. A push happens on every commit edge when the FIFO is not full,
// or when it is full and a pop happens on the same edge. A commit into a full
// FIFO with no pop is dropped and sets overflow.
// -----------------------------------------------------------------------------
module sevenseg_receiver #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       valid,
  output logic       update,
  output logic       bad_pattern,
  output logic [7:0] change_count,
  input  logic       rd_en,
  output logic [4:0] rd_data,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  output logic       state_o
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [6:0] seg_q;
  logic [6:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] committed_q, committed_d;
  logic [3:0] value_q, value_d;
  logic       bad_q, bad_d;
  logic       update_q, update_d;
  logic [7:0] cc_q, cc_d;

  logic [4:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       ovf_q, ovf_d;

  logic       stable;
  logic       commit;
  logic [3:0] dec_val;
  logic       dec_bad;
  logic       f_empty, f_full;
  logic       pop, push_ok;

  // ---------------------------------------------------------------------------
  // Debounce front end: a candidate is (re)started whenever the registered bus
  // disagrees with it; otherwise the counter runs up and parks at CNT_MAX so a
  // held pattern stays "stable" indefinitely.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (seg_q != cand_q) begin
      cand_d = seg_q;
      cnt_d  = 4'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign stable = (seg_q == cand_q) && (cnt_q == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Decode table, applied to the candidate that is about to commit
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_val = 4'hF;
    dec_bad = 1'b0;
    case (cand_q)
      7'h3F:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5B:   dec_val = 4'd2;
      7'h4F:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6D:   dec_val = 4'd5;
      7'h7D:   dec_val = 4'd6;
      7'h07:   dec_val = 4'd7;
      7'h7F:   dec_val = 4'd8;
      7'h6F:   dec_val = 4'd9;
      7'h00:   dec_val = 4'd12;
      default: begin
        dec_val = 4'hF;
        dec_bad = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: WAIT accepts any stable pattern; LOCKED only accepts a stable pattern
  // that differs from the one already committed.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    if (state_q == ST_WAIT) begin
      if (stable) begin
        commit  = 1'b1;
        state_d = ST_LOCKED;
      end
    end else begin
      if (stable && (cand_q != committed_q)) begin
        commit = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Committed-result datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    committed_d = committed_q;
    value_d     = value_q;
    bad_d       = bad_q;
    update_d    = commit;
    cc_d        = cc_q;
    if (commit) begin
      committed_d = cand_q;
      value_d     = dec_val;
      bad_d       = dec_bad;
      if (cc_q != 8'hFF) begin
        cc_d = cc_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 4-entry FIFO. Pop is qualified by non-empty first, so a push into an empty
  // FIFO with rd_en high just pushes; when full, a coincident pop frees the
  // slot the push needs.
  // ---------------------------------------------------------------------------
  assign f_empty = (fcnt_q == 3'd0);
  assign f_full  = (fcnt_q == 3'd4);
  assign pop     = rd_en && !f_empty;
  assign push_ok = commit && (!f_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (commit && f_full && !pop) begin
      ovf_d = 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + 3'd1;
      2'b01:   fcnt_d = fcnt_q - 3'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      seg_q       <= 7'd0;
      cand_q      <= 7'd0;
      cnt_q       <= 4'd0;
      committed_q <= 7'd0;
      value_q     <= 4'd0;
      bad_q       <= 1'b0;
      update_q    <= 1'b0;
      cc_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      value_q     <= value_d;
      bad_q       <= bad_d;
      update_q    <= update_d;
      cc_q        <= cc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 5'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      fcnt_q   <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {dec_bad, dec_val};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign value        = value_q;
  assign valid        = (state_q == ST_LOCKED);
  assign update       = update_q;
  assign bad_pattern  = bad_q;
  assign change_count = cc_q;
  assign rd_data      = f_empty ? 5'd0 : mem_q[rd_ptr_q];
  assign fifo_empty   = f_empty;
  assign fifo_full    = f_full;
  assign overflow     = ovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sevenseg_receiver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_receiver
//
// Drives held segment patterns (directed scenarios, then random patterns and
// hold lengths with random FIFO reads). A reference model predicts commits from
// the rule "the last STABLE_CYCLES+1 samples before this edge are all the same
// pattern, and it differs from the committed one", plus a queue-based FIFO.
// Predicted commits go into exp_q; the monitor pops on each update pulse.
// -----------------------------------------------------------------------------
module tb_sevenseg_receiver;

  localparam int S = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg   = 7'd0;
  logic       rd_en = 1'b0;
  logic [3:0] value;
  logic       valid;
  logic       update;
  logic       bad_pattern;
  logic [7:0] change_count;
  logic [4:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic       state_o;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  sevenseg_receiver #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg          (seg),
    .value        (value),
    .valid        (valid),
    .update       (update),
    .bad_pattern  (bad_pattern),
    .change_count (change_count),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .state_o      (state_o)
  );

  int   total  = 0;
  int   bad    = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [6:0]  hist[$];
  logic        have_m      = 1'b0;
  logic [6:0]  committed_m = 7'd0;
  logic [3:0]  value_m     = 4'd0;
  logic        bad_m       = 1'b0;
  int          cc_m        = 0;
  logic [4:0]  fifo_m[$];
  logic        ovf_m       = 1'b0;
  logic        exp_upd     = 1'b0;
  logic [12:0] exp_q[$];

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (p == digit_pat[i]) return {1'b0, 4'(i)};
    end
    if (p == 7'h00) return 5'h0C;
    return 5'h1F;
  endfunction

  // Reset leaves the front end as if 0 had already been seen on two edges.
  task automatic model_reset();
    if (mon_en) chk("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    hist.delete();
    hist.push_back(7'd0);
    hist.push_back(7'd0);
    have_m      = 1'b0;
    committed_m = 7'd0;
    value_m     = 4'd0;
    bad_m       = 1'b0;
    cc_m        = 0;
    fifo_m.delete();
    ovf_m       = 1'b0;
    exp_upd     = 1'b0;
  endtask

  always @(posedge clk) begin : model_p
    logic       same;
    logic [6:0] p;
    logic [4:0] d;
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_upd = 1'b0;
      same = (hist.size() >= S + 1);
      p    = hist[hist.size() - 1];
      for (int i = 0; i < hist.size(); i++) begin
        if (hist[i] != p) same = 1'b0;
      end
      if (rd_en && fifo_m.size() > 0) void'(fifo_m.pop_front());
      if (same && (!have_m || p != committed_m)) begin
        d           = ref_decode(p);
        have_m      = 1'b1;
        committed_m = p;
        value_m     = d[3:0];
        bad_m       = d[4];
        if (cc_m < 255) cc_m++;
        exp_upd = 1'b1;
        exp_q.push_back({8'(cc_m), d});
        if (fifo_m.size() < 4) fifo_m.push_back(d);
        else ovf_m = 1'b1;
      end
      hist.push_back(seg);
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor_p
    logic [12:0] e;
    if (mon_en && rst_n) begin
      chk("update", update, exp_upd);
      if (update) begin
        chk("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("upd_value", value, e[3:0]);
          chk("upd_bad", bad_pattern, e[4]);
          chk("upd_count", change_count, e[12:5]);
        end
      end
      chk("value", value, value_m);
      chk("bad_pattern", bad_pattern, bad_m);
      chk("valid", valid, have_m);
      chk("state", state_o, have_m);
      chk("change_count", change_count, cc_m);
      chk("rd_data", rd_data, (fifo_m.size() > 0) ? fifo_m[0] : 5'd0);
      chk("fifo_empty", fifo_empty, fifo_m.size() == 0);
      chk("fifo_full", fifo_full, fifo_m.size() == 4);
      chk("overflow", overflow, ovf_m);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_value", value, 0);
    chk("rst_valid", valid, 0);
    chk("rst_update", update, 0);
    chk("rst_bad", bad_pattern, 0);
    chk("rst_count", change_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", state_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold pattern p for n rising edges; rd_en is high on edge rd_edge (0 = never).
  task automatic hold(input logic [6:0] p, input int n, input int rd_edge);
    seg = p;
    for (int j = 1; j <= n; j++) begin
      rd_en = (j == rd_edge);
      @(posedge clk);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input logic [4:0] e);
    chk("pop_head", rd_data, e);
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [6:0] p;
    int         n;
    int         r;

    do_reset();
    mon_en = 1'b1;

    // First commit lands after the sixth edge.
    hold(7'h5B, 5, 0);
    chk("t1_no_early_update", update, 0);
    hold(7'h5B, 1, 0);
    chk("t1_update", update, 1);
    chk("t1_value", value, 2);
    chk("t1_valid", valid, 1);
    chk("t1_count", change_count, 1);
    chk("t1_rd_data", rd_data, 5'h02);

    // Short glitch back to the committed pattern: no new commit.
    hold(7'h06, 8, 0);
    chk("t2_commit_1", value, 1);
    hold(7'h7F, 2, 0);
    hold(7'h06, 8, 0);
    chk("t2_count", change_count, 2);
    chk("t2_value", value, 1);

    // Unknown pattern.
    do_reset();
    hold(7'h49, 6, 0);
    chk("t3_update", update, 1);
    chk("t3_value", value, 4'hF);
    chk("t3_bad", bad_pattern, 1);
    chk("t3_rd_data", rd_data, 5'h1F);

    // Blank held from reset release commits as the first pattern.
    do_reset();
    hold(7'h00, 4, 0);
    chk("t4_blank_update", update, 1);
    chk("t4_blank_value", value, 12);

    // Five commits, no reads: overflow, then drain.
    do_reset();
    hold(7'h3F, 6, 0);
    hold(7'h06, 6, 0);
    hold(7'h5B, 6, 0);
    hold(7'h4F, 6, 0);
    hold(7'h66, 6, 0);
    chk("t5_full", fifo_full, 1);
    chk("t5_ovf", overflow, 1);
    pop_chk(5'h00);
    pop_chk(5'h01);
    pop_chk(5'h02);
    pop_chk(5'h03);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_empty_data", rd_data, 0);

    // Full FIFO, pop coincident with commit of 7.
    do_reset();
    hold(7'h3F, 6, 0);
    hold(7'h06, 6, 0);
    hold(7'h5B, 6, 0);
    hold(7'h4F, 6, 0);
    chk("t6_full_before", fifo_full, 1);
    hold(7'h07, 6, 6);
    chk("t6_update", update, 1);
    chk("t6_full", fifo_full, 1);
    chk("t6_ovf", overflow, 0);
    pop_chk(5'h01);
    pop_chk(5'h02);
    pop_chk(5'h03);
    pop_chk(5'h07);
    chk("t6_empty", fifo_empty, 1);

    // 300 commits saturate the counter, then reset mid-window.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      hold((i % 2 == 1) ? 7'h06 : 7'h3F, 6, 0);
    end
    chk("t7_saturated", change_count, 255);
    hold(7'h7F, 3, 0);
    do_reset();
    hold(7'h7F, 5, 0);
    chk("t7_window_restart", update, 0);
    hold(7'h7F, 1, 0);
    chk("t7_update", update, 1);
    chk("t7_value", value, 8);
    chk("t7_count", change_count, 1);

    // Random patterns, hold lengths and reads.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      p = 7'($urandom_range(0, 127));
      else if (r == 1) p = 7'h00;
      else             p = digit_pat[$urandom_range(0, 9)];
      n = $urandom_range(1, 9);
      hold(p, n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0);
    end
    hold(seg, 8, 0);
    chk("end_exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
